// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU issue path and the ALU itself:
//   ALU control codes, the major opcodes the issue stage decodes,
//   skid-buffer occupancy values, the packed issue-entry struct and
//   small decode helpers.
//   No ports (package).
package alu_pkg;

  localparam int ALU_XLEN = 32;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1100;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct7 values accepted on R-type
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Skid-buffer occupancy
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef struct packed {
    logic [3:0]          ctrl;
    logic [ALU_XLEN-1:0] inp1;
    logic [ALU_XLEN-1:0] inp2;
    logic [4:0]          rd;
    logic                illegal;
  } alu_entry_t;

  // Shared R/I funct3 map. alt selects SUB on 000 and SRA on 101.
  function automatic logic [3:0] funct3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode
//   Purely combinational decode of one instruction packet into an ALU
//   issue entry (control code, two operands, destination tag, illegal).
//   Ports:
//     opcode, funct3, funct7  in   decoded instruction fields
//     rs1_data, rs2_data      in   register operands
//     imm                     in   sign-extended I/S/B or shifted U immediate
//     rd_in                   in   destination tag
//     entry                   out  decoded issue entry
module alu_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_in,
  output alu_entry_t      entry
);

  logic [3:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            bad;

  always_comb begin
    op    = ALU_ADD;
    src_a = rs1_data;
    src_b = rs2_data;
    bad   = 1'b0;
    case (opcode)
      OP_R: begin
        if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) bad = 1'b1;
        else                                          op  = funct3_op(funct3, funct7[5]);
      end
      OP_I: begin
        src_b = imm;
        // funct7[5] is the arithmetic-shift flag only for SRLI/SRAI;
        // on ADDI it is just an immediate bit and must not select SUB.
        op    = funct3_op(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OP_LOAD, OP_STORE: begin
        src_b = imm;
        op    = ALU_ADD;
      end
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   op  = ALU_SUB;
          2'b10:   op  = ALU_SLT;
          2'b11:   op  = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OP_LUI: begin
        src_a = '0;
        src_b = imm;
        op    = ALU_ADD;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    entry.rd = rd_in;
    if (bad) begin
      entry.ctrl    = ALU_AND;
      entry.inp1    = '0;
      entry.inp2    = '0;
      entry.illegal = 1'b1;
    end else begin
      entry.ctrl    = op;
      entry.inp1    = src_a;
      // The ALU shifts by its whole second operand, so only the 5-bit
      // shift amount may survive.
      entry.inp2    = is_shift(op) ? {{(XLEN-5){1'b0}}, src_b[4:0]} : src_b;
      entry.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Registered ALU issue stage. Decodes an instruction packet and holds
//   up to two decoded entries in a FIFO skid buffer so the ALU side can
//   stall without losing work. Outputs come straight from the head
//   register; in_ready is registered and independent of out_ready.
//   Ports:
//     clk, reset (sync, active-high), flush (sync)
//     in_valid/in_ready        upstream handshake
//     opcode, funct3, funct7, rs1_data, rs2_data, imm, rd_in   packet
//     out_valid/out_ready      downstream handshake
//     ALU_control, inp1, inp2, rd_out, illegal                 head entry
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALU_control,
  output logic [XLEN-1:0] inp1,
  output logic [XLEN-1:0] inp2,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  alu_entry_t dec_p0;
  alu_entry_t head_p1;
  alu_entry_t tail_p1;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .rd_in    (rd_in),
    .entry    (dec_p0)
  );

  assign out_valid = (count != CNT_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    case (count)
      CNT_EMPTY: if (push)         count_nxt = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)          count_nxt = CNT_FULL;
        else if (pop && !push)     count_nxt = CNT_EMPTY;
      end
      CNT_FULL:  if (pop)          count_nxt = CNT_ONE;
      default:                     count_nxt = CNT_EMPTY;
    endcase
  end

  // ---- decode -> skid buffer registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= CNT_EMPTY;
      in_ready <= 1'b1;
      head_p1  <= '0;
      tail_p1  <= '0;
    end else if (flush) begin
      // Any push this cycle is dropped; data registers are left as-is
      // because out_valid is low.
      count    <= CNT_EMPTY;
      in_ready <= 1'b1;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != CNT_FULL);
      case (count)
        CNT_EMPTY: if (push) head_p1 <= dec_p0;
        CNT_ONE: begin
          if (push && pop)   head_p1 <= dec_p0;
          else if (push)     tail_p1 <= dec_p0;
        end
        CNT_FULL:  if (pop)  head_p1 <= tail_p1;
        default: ;
      endcase
    end
  end

  assign ALU_control = head_p1.ctrl;
  assign inp1        = head_p1.inp1;
  assign inp2        = head_p1.inp2;
  assign rd_out      = head_p1.rd;
  assign illegal     = head_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Bench for alu_issue: directed scenarios followed by random traffic,
//   checked against a queue-based reference model of the issue stage.
module tb_alu_issue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALU_control;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [4:0]  rd_out;
  logic        illegal;

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .rd_in       (rd_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_control (ALU_control),
    .inp1        (inp1),
    .inp2        (inp2),
    .rd_out      (rd_out),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   model_rdy;
  bit   zero_data;
  int   n_vec;
  int   n_err;

  function automatic logic [3:0] code_of(input string name);
    if (name == "AND")  return 4'd0;
    if (name == "OR")   return 4'd1;
    if (name == "ADD")  return 4'd2;
    if (name == "SLT")  return 4'd3;
    if (name == "SRL")  return 4'd4;
    if (name == "SLL")  return 4'd5;
    if (name == "SUB")  return 4'd6;
    if (name == "SLTU") return 4'd7;
    if (name == "SRA")  return 4'd8;
    return 4'd12; // XOR
  endfunction

  // Reference decode from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] im,
                                      input logic [4:0] rd);
    string names[8];
    string name;
    bit    bad;
    bit    use_imm;
    bit    zero_a;
    exp_t  e;
    names   = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    name    = "ADD";
    bad     = 0;
    use_imm = 0;
    zero_a  = 0;
    if (op == 7'h33) begin
      if (f7 != 7'h00 && f7 != 7'h20) bad = 1;
      else begin
        name = names[f3];
        if (f7 == 7'h20 && f3 == 0) name = "SUB";
        if (f7 == 7'h20 && f3 == 5) name = "SRA";
      end
    end else if (op == 7'h13) begin
      use_imm = 1;
      name    = names[f3];
      if (f3 == 5 && f7[5]) name = "SRA";
    end else if (op == 7'h03 || op == 7'h23) begin
      use_imm = 1;
    end else if (op == 7'h63) begin
      if (f3 == 0 || f3 == 1)      name = "SUB";
      else if (f3 == 4 || f3 == 5) name = "SLT";
      else if (f3 == 6 || f3 == 7) name = "SLTU";
      else                         bad = 1;
    end else if (op == 7'h37) begin
      use_imm = 1;
      zero_a  = 1;
    end else begin
      bad = 1;
    end
    e.rd = rd;
    if (bad) begin
      e.ctrl = 0; e.a = 0; e.b = 0; e.ill = 1;
    end else begin
      e.ctrl = code_of(name);
      e.a    = zero_a ? 32'd0 : a;
      e.b    = use_imm ? im : b;
      if (name == "SLL" || name == "SRL" || name == "SRA") e.b = e.b % 32;
      e.ill  = 0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit   push;
    bit   pop;
    exp_t e;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, model_rdy});
    check("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) begin
      check("ctrl", {28'd0, ALU_control}, {28'd0, q[0].ctrl});
      check("inp1", inp1, q[0].a);
      check("inp2", inp2, q[0].b);
      check("rd", {27'd0, rd_out}, {27'd0, q[0].rd});
      check("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
    end else if (zero_data) begin
      check("rst_ctrl", {28'd0, ALU_control}, 32'd0);
      check("rst_inp1", inp1, 32'd0);
      check("rst_inp2", inp2, 32'd0);
      check("rst_rd", {27'd0, rd_out}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
    end
    push = in_valid && model_rdy;
    pop  = (q.size() > 0) && out_ready;
    e    = ref_decode(opcode, funct3, funct7, rs1_data, rs2_data, imm, rd_in);
    @(posedge clk);
    if (reset) begin
      q.delete();
      zero_data = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        zero_data = 0;
      end
    end
    model_rdy = (q.size() < 2);
    #1;
  endtask

  task automatic set_pkt(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im; rd_in = rd;
  endtask

  task automatic rand_pkt();
    logic [6:0] op;
    logic [6:0] f7;
    case ($urandom_range(0, 7))
      0:       op = 7'h33;
      1:       op = 7'h13;
      2:       op = 7'h03;
      3:       op = 7'h23;
      4:       op = 7'h63;
      5:       op = 7'h37;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    set_pkt(op, 3'($urandom), f7, $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    set_pkt(7'h33, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    q.delete(); model_rdy = 1; zero_data = 1;
    reset = 0;
    tick();

    // R-type SUB
    set_pkt(7'h33, 3'b000, 7'h20, 32'd10, 32'd3, 32'h55, 5'd7);
    in_valid = 1;
    tick();
    in_valid = 0;
    check("sub_ctrl", {28'd0, ALU_control}, 32'h6);
    check("sub_inp1", inp1, 32'd10);
    check("sub_inp2", inp2, 32'd3);
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // SRAI with upper immediate bits set
    set_pkt(7'h13, 3'b101, 7'h20, 32'h80000000, 32'hFFFF_FFFF, 32'h00000405, 5'd9);
    in_valid = 1;
    tick();
    in_valid = 0;
    check("srai_ctrl", {28'd0, ALU_control}, 32'h8);
    check("srai_inp2", inp2, 32'd5);

    // BLTU
    set_pkt(7'h63, 3'b110, 7'h00, 32'd1, 32'd2, 32'h10, 5'd0);
    in_valid = 1;
    tick();
    check("bltu_ctrl", {28'd0, ALU_control}, 32'h7);

    // Unknown opcode
    set_pkt(7'h7F, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 5'd17);
    tick();
    check("bad_illegal", {31'd0, illegal}, 32'd1);
    check("bad_ctrl", {28'd0, ALU_control}, 32'd0);
    check("bad_rd", {27'd0, rd_out}, 32'd17);

    // LUI
    set_pkt(7'h37, 3'b000, 7'h00, 32'hDEAD_BEEF, 32'd2, 32'h12345000, 5'd3);
    tick();
    in_valid = 0;
    check("lui_ctrl", {28'd0, ALU_control}, 32'h2);
    check("lui_inp1", inp1, 32'd0);
    check("lui_inp2", inp2, 32'h12345000);
    tick();

    // Backpressure: three back-to-back packets against a stalled output
    out_ready = 0;
    in_valid  = 1;
    set_pkt(7'h33, 3'b111, 7'h00, 32'hA, 32'hB, 32'h0, 5'd1);
    tick();
    set_pkt(7'h33, 3'b110, 7'h00, 32'hC, 32'hD, 32'h0, 5'd2);
    tick();
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    set_pkt(7'h33, 3'b100, 7'h00, 32'hE, 32'hF, 32'h0, 5'd3);
    tick();
    check("bp_hold_rd", {27'd0, rd_out}, 32'd1);
    in_valid  = 0;
    out_ready = 1;
    tick();
    check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    check("bp_second_rd", {27'd0, rd_out}, 32'd2);
    tick();
    tick();

    // Flush while full, with a simultaneous push
    out_ready = 0;
    in_valid  = 1;
    set_pkt(7'h13, 3'b000, 7'h00, 32'd1, 32'd0, 32'd1, 5'd4);
    tick();
    set_pkt(7'h13, 3'b000, 7'h00, 32'd2, 32'd0, 32'd1, 5'd5);
    tick();
    flush = 1;
    set_pkt(7'h13, 3'b000, 7'h00, 32'd3, 32'd0, 32'd1, 5'd6);
    tick();
    flush = 0; in_valid = 0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1;
    tick();
    tick();

    // Same sequence with reset
    out_ready = 0;
    in_valid  = 1;
    set_pkt(7'h33, 3'b001, 7'h00, 32'd7, 32'h23, 32'd0, 5'd8);
    tick();
    set_pkt(7'h33, 3'b010, 7'h00, 32'd8, 32'd9, 32'd0, 5'd9);
    tick();
    reset = 1;
    set_pkt(7'h33, 3'b011, 7'h00, 32'd9, 32'd9, 32'd0, 5'd10);
    tick();
    reset = 0; in_valid = 0;
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_ctrl", {28'd0, ALU_control}, 32'd0);
    check("rst2_inp1", inp1, 32'd0);
    check("rst2_inp2", inp2, 32'd0);
    check("rst2_rd", {27'd0, rd_out}, 32'd0);
    out_ready = 1;
    tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_pkt();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered issue stage that drives the single-cycle core's ALU. Accepts a decoded-field instruction packet (opcode/funct3/funct7, register operands, immediate, destination tag) over a valid/ready handshake. Produces the 4-bit ALU control code and the two ALU operands through a 2-entry skid buffer, so the ALU and writeback side can stall without dropping work. Sits between register-file read and the ALU.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  registered; stage can accept this cycle.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- rs1_data  in  32  register operand 1.
- rs2_data  in  32  register operand 2.
- imm  in  32  sign-extended I/S/B immediate, or U immediate (already shifted left by 12).
- rd_in  in  5  destination tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- ALU_control  out  4  ALU op code for head entry.
- inp1  out  32  ALU operand 1.
- inp2  out  32  ALU operand 2.
- rd_out  out  5  tag of head entry.
- illegal  out  1  head entry had an unsupported encoding.

## Operation
ALU codes:
- AND 0000, OR 0001, ADD 0010, SLT 0011, SRL 0100, SLL 0101, SUB 0110, SLTU 0111, SRA 1000, XOR 1100.

Decode:
- R-type (0110011): operands rs1, rs2.
  - funct3 000: SUB if funct7[5], else ADD.
  - funct3 001: SLL.
  - funct3 010: SLT.
  - funct3 011: SLTU.
  - funct3 100: XOR.
  - funct3 101: SRA if funct7[5], else SRL.
  - funct3 110: OR.
  - funct3 111: AND.
- I-ALU (0010011): same funct3 map with operands rs1, imm.
  - funct3 000 is always ADD.
  - funct7[5] selects SRA only for funct3 101.
- Load (0000011) and store (0100011): ADD, operands rs1, imm.
- Branch (1100011): operands rs1, rs2.
  - funct3 000/001: SUB.
  - funct3 100/101: SLT.
  - funct3 110/111: SLTU.
  - funct3 010/011: illegal.
- LUI (0110111): ADD with inp1=0, inp2=imm.
- Shifts (SLL/SRL/SRA): inp2 = {27'b0, source[4:0]}. Upper bits are always zeroed, because the ALU shifts by the full operand.
- Any other opcode, or R-type funct7 not in {0000000, 0100000}: entry still enqueues with illegal=1, ALU_control=0000, inp1=inp2=0, rd_out unchanged.

Skid buffer:
- States EMPTY(0), ONE(1), FULL(2), held as an entry count.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Transitions:
  - EMPTY to ONE on push.
  - ONE to FULL on push without pop.
  - ONE to EMPTY on pop without push.
  - ONE to ONE on simultaneous push and pop.
  - FULL to ONE on pop (no push is possible in FULL).
- Order is FIFO: the head is always the oldest entry.
- in_ready is asserted for the next cycle when the next count is below 2.
- flush: next count becomes 0, so out_valid=0 next cycle and in_ready=1. A push in the same cycle as flush is discarded; flush has priority.
- reset: same effect as flush, and also zeroes all output data registers.

## Timing
- Reset values: out_valid=0, in_ready=1, ALU_control=0000, inp1=0, inp2=0, rd_out=0, illegal=0.
- Latency: a packet accepted at edge N is presented at outputs from edge N (out_valid=1 in cycle N+1). There is no combinational path from inputs to outputs.
- Throughput: one packet per cycle with out_ready held high.
- Output data must stay stable while out_valid && !out_ready.
- in_ready must not depend combinationally on out_ready.
- Reset or flush mid-stall drops the stalled head with no partial output.

## Structure
- Shared package alu_pkg holds:
  - ALU code localparams (ALU_AND … ALU_XOR).
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI.
  - A packed entry struct {ctrl, inp1, inp2, rd, illegal}.
- The ALU module uses the same package codes.
- One combinational sub-module, alu_decode, maps {opcode, funct3, funct7, rs1, rs2, imm} to an entry struct.
- alu_issue holds only the two entry registers, the count, and the handshake logic.

## Test plan
- R-type SUB: rs1=10, rs2=3, funct7=0100000, funct3=000, out_ready=1 → next cycle ALU_control=0110, inp1=10, inp2=3, out_valid=1.
- I-type SRAI: rs1=0x80000000, imm=0x00000405 → ALU_control=1000, inp2=5 (upper bits masked).
- Backpressure: out_ready=0, push 3 back-to-back packets → first two accepted, in_ready=0 after the second push. Then release out_ready → outputs emerge in order, in_ready=1 one cycle after the first pop.
- Branch BLTU (funct3=110) → ALU_control=0111. Opcode 1111111 → illegal=1, ALU_control=0000.
- LUI with imm=0x12345000 → ALU_control=0010, inp1=0, inp2=0x12345000.
- Count at 2, then flush asserted together with in_valid → next cycle out_valid=0, in_ready=1, flushed packet never appears. Repeat the same sequence with reset → all outputs at reset values.
